// File: rtl/fir_mac_engine_pkg.sv
// rtl/fir_mac_engine_pkg.sv - shared types, default widths and saturation helper for the FIR MAC engine
//
// Purpose: FSM state encoding, default parameter values and the
//          scale/saturate helper used by the output stage.
// Ports:   none (package)

package fir_mac_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } fir_state_t;

  localparam int NTAPS_DEF  = 10;
  localparam int IN_W_DEF   = 24;
  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;
  localparam int OUT_W_DEF  = 16;

  // Working width of the saturation helper; every accumulator is sign-extended to it.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_result_t;

  // Clamp v into the signed out_w-bit range and flag whether clamping happened.
  function automatic sat_result_t sat_trunc(input logic signed [SAT_W-1:0] v,
                                            input int unsigned out_w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_result_t r;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    r.sat = 1'b0;
    r.val = v;
    if (v > max_v) begin
      r.sat = 1'b1;
      r.val = max_v;
    end else if (v < min_v) begin
      r.sat = 1'b1;
      r.val = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// rtl/fir_mac_engine_if.sv - sample, coefficient-ROM and result signals of the FIR MAC engine
//
// Purpose: bundles the sample input, the coefficient ROM port and the
//          filtered-result outputs.
// Signals: sample_valid/sample/gain_shift (in), coef_addr (out) / coef_data (in),
//          busy, sample_dropped, out_valid, out_data, out_sat (out).
// Modports: slave = the filter engine, master = the surrounding system.

interface fir_mac_engine_if #(
  parameter int NTAPS  = 10,
  parameter int IN_W   = 24,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16
);
  localparam int AW = $clog2(NTAPS);

  logic                     sample_valid;
  logic [IN_W-1:0]          sample;
  logic [4:0]               gain_shift;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     busy;
  logic                     sample_dropped;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;

  modport slave (
    input  sample_valid, sample, gain_shift, coef_data,
    output coef_addr, busy, sample_dropped, out_valid, out_data, out_sat
  );

  modport master (
    output sample_valid, sample, gain_shift, coef_data,
    input  coef_addr, busy, sample_dropped, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/fir_mac_engine_delay_line.sv
// rtl/fir_mac_engine_delay_line.sv - circular sample history with registered tap read
//
// Purpose: NTAPS x DATA_W circular buffer. New samples are written at wr_ptr;
//          the tap read returns history[(wr_ptr - rd_tap) mod NTAPS] one cycle later.
// Ports:   clk, reset      clock, sync active-high clear of history and pointer
//          wr_en, wr_data  write the newest sample at wr_ptr
//          advance         move wr_ptr to the next slot (mod NTAPS)
//          rd_tap          tap index k
//          rd_data         registered sample x[n-k]

module fir_mac_engine_delay_line #(
  parameter int NTAPS  = 10,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic signed [DATA_W-1:0]   wr_data,
  input  logic                       advance,
  input  logic [$clog2(NTAPS)-1:0]   rd_tap,
  output logic signed [DATA_W-1:0]   rd_data
);
  localparam int AW = $clog2(NTAPS);

  logic signed [DATA_W-1:0] hist [NTAPS];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_idx;

  // (wr_ptr - k) mod NTAPS: add NTAPS back when k reaches past slot 0. The sum is
  // evaluated modulo 2^AW, which is exact because the true result is < NTAPS.
  always_comb begin
    rd_idx = wr_ptr - rd_tap;
    if (rd_tap > wr_ptr) begin
      rd_idx = wr_ptr - rd_tap + AW'(NTAPS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        hist[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        hist[wr_ptr] <= wr_data;
      end
      if (advance) begin
        wr_ptr <= (wr_ptr == AW'(NTAPS - 1)) ? '0 : wr_ptr + AW'(1);
      end
      rd_data <= hist[rd_idx];
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - time-multiplexed single-multiplier FIR filter with gain shift and saturation
//
// Purpose: y[n] = sum h[k]*x[n-k], one tap per cycle through a single multiplier,
//          then arithmetic right shift by gain_shift and saturation to OUT_W.
// Ports:   clk    clock
//          reset  sync, active-high; aborts any computation and clears history
//          bus    fir_mac_engine_if.slave: sample in, coefficient ROM port, result out

module fir_mac_engine
  import fir_mac_engine_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input logic             clk,
  input logic             reset,
  fir_mac_engine_if.slave bus
);
  localparam int AW = $clog2(NTAPS);
  localparam int PW = DATA_W + COEF_W;

  if (NTAPS < 2) begin : g_bad_ntaps
    $error("fir_mac_engine: NTAPS must be at least 2");
  end
  if (ACC_W < DATA_W + COEF_W + $clog2(NTAPS)) begin : g_bad_acc_w
    $error("fir_mac_engine: ACC_W too narrow, accumulator could wrap");
  end
  if (ACC_W > SAT_W || OUT_W >= SAT_W || IN_W < DATA_W) begin : g_bad_widths
    $error("fir_mac_engine: unsupported width combination");
  end

  fir_state_t               state, state_nxt;
  logic [AW-1:0]            cnt, cnt_nxt;
  logic                     accept;
  logic                     ptr_advance;
  logic [4:0]               gain_q;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] x_reg;
  logic                     tap_v1;
  logic                     tap_v2;
  logic signed [PW-1:0]     prod_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_shift;
  sat_result_t              sat_res;
  logic signed [OUT_W-1:0]  out_live;
  logic signed [OUT_W-1:0]  out_hold;
  logic                     sat_hold;

  assign x_in        = bus.sample[IN_W-1 -: DATA_W];
  assign accept      = (state == IDLE) && bus.sample_valid;
  assign ptr_advance = (state == DRAIN) && (cnt == AW'(1));

  if (IN_W > DATA_W) begin : g_low_bits
    logic unused_low;
    assign unused_low = ^bus.sample[IN_W-DATA_W-1:0];
  end

  // cnt is the tap index k in RUN and the flush-cycle index in DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.sample_valid) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (cnt == AW'(NTAPS - 1)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      DRAIN: begin
        if (cnt == AW'(1)) begin
          state_nxt = OUT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      OUT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The ROM address and the history read are issued in the same cycle so that
  // coef_data and x_reg line up one cycle later.
  assign bus.coef_addr = (state == RUN) ? cnt : '0;

  fir_mac_engine_delay_line #(
    .NTAPS  (NTAPS),
    .DATA_W (DATA_W)
  ) u_delay_line (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data (x_in),
    .advance (ptr_advance),
    .rd_tap  (cnt),
    .rd_data (x_reg)
  );

  // tap_v1: coef_data/x_reg hold a live tap; tap_v2: prod_q holds a live product.
  always_ff @(posedge clk) begin
    if (reset) begin
      gain_q   <= '0;
      tap_v1   <= 1'b0;
      tap_v2   <= 1'b0;
      prod_q   <= '0;
      acc      <= '0;
      out_hold <= '0;
      sat_hold <= 1'b0;
    end else begin
      tap_v1 <= (state == RUN);
      tap_v2 <= tap_v1;
      prod_q <= PW'(bus.coef_data) * PW'(x_reg);
      if (accept) begin
        gain_q <= bus.gain_shift;
        acc    <= '0;
      end else if (tap_v2) begin
        acc <= acc + ACC_W'(prod_q);
      end
      if (state == OUT) begin
        out_hold <= out_live;
        sat_hold <= sat_res.sat;
      end
    end
  end

  // The final accumulate lands on the edge entering OUT, so the result is
  // presented straight from acc during OUT and held in out_hold afterwards.
  assign acc_shift = acc >>> gain_q;
  assign sat_res   = sat_trunc(SAT_W'(acc_shift), OUT_W);
  assign out_live  = sat_res.val[OUT_W-1:0];

  logic unused_sat_hi;
  assign unused_sat_hi = ^sat_res.val[SAT_W-1:OUT_W];

  assign bus.busy           = (state != IDLE);
  assign bus.sample_dropped = bus.sample_valid && (state != IDLE);
  assign bus.out_valid      = (state == OUT);
  assign bus.out_data       = (state == OUT) ? out_live : out_hold;
  assign bus.out_sat        = (state == OUT) ? sat_res.sat : sat_hold;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - self-checking bench for fir_mac_engine (10-tap and 5-tap instances)

module tb_fir_mac_engine;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_mac_engine_if #(.NTAPS(10), .IN_W(24), .COEF_W(16), .OUT_W(16)) bus10 ();
  fir_mac_engine_if #(.NTAPS(5),  .IN_W(24), .COEF_W(16), .OUT_W(16)) bus5 ();

  fir_mac_engine #(.NTAPS(10)) dut10 (.clk(clk), .reset(reset), .bus(bus10));
  fir_mac_engine #(.NTAPS(5))  dut5  (.clk(clk), .reset(reset), .bus(bus5));

  // Coefficient ROM contents, shared by both instances; each gets its own 1-cycle read port.
  logic signed [15:0] coef [10];
  always @(posedge clk) begin
    bus10.coef_data <= coef[bus10.coef_addr];
    bus5.coef_data  <= coef[bus5.coef_addr];
  end

  // Reference model: newest sample at index 0 of each history.
  int     ntaps [2] = '{10, 5};
  longint hist [2][10];

  function automatic void model_clear();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 10; i++) hist[w][i] = 0;
  endfunction

  function automatic void model_push(input int w, input logic [23:0] raw);
    logic signed [15:0] x;
    x = raw[23:8];
    for (int i = 9; i > 0; i--) hist[w][i] = hist[w][i-1];
    hist[w][0] = longint'(x);
  endfunction

  function automatic longint model_y(input int w, input int sh, output bit sat);
    longint s;
    s = 0;
    for (int k = 0; k < ntaps[w]; k++) s += longint'(coef[k]) * hist[w][k];
    s = s >>> sh;
    sat = 1'b0;
    if (s > 32767) begin s = 32767; sat = 1'b1; end
    else if (s < -32768) begin s = -32768; sat = 1'b1; end
    return s;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [23:0] raw, input logic [4:0] sh);
    if (w == 0) begin
      bus10.sample_valid = v; bus10.sample = raw; bus10.gain_shift = sh;
    end else begin
      bus5.sample_valid = v; bus5.sample = raw; bus5.gain_shift = sh;
    end
  endtask

  function automatic logic o_valid(input int w);   return w ? bus5.out_valid : bus10.out_valid; endfunction
  function automatic logic o_busy(input int w);    return w ? bus5.busy : bus10.busy; endfunction
  function automatic logic o_dropped(input int w); return w ? bus5.sample_dropped : bus10.sample_dropped; endfunction
  function automatic logic o_sat(input int w);     return w ? bus5.out_sat : bus10.out_sat; endfunction
  function automatic longint o_data(input int w);
    return w ? longint'(bus5.out_data) : longint'(bus10.out_data);
  endfunction

  // Accept one sample, then watch for its result. Inputs other than sample_valid
  // are scrambled after accept so a missing gain latch shows up. drop1/drop2 name
  // cycles (after accept) at which an extra sample_valid is pulsed.
  task automatic send(input int w, input logic [23:0] raw, input logic [4:0] sh,
                      input int drop1, input int drop2);
    int     lat;
    int     seen;
    bit     sv_high;
    bit     exp_s;
    longint exp_d;
    lat = ntaps[w] + 3;
    @(negedge clk);
    set_in(w, 1'b1, raw, sh);
    model_push(w, raw);
    exp_d   = model_y(w, int'(sh), exp_s);
    seen    = 0;
    sv_high = 1'b0;
    for (int c = 1; c <= lat + 3; c++) begin
      @(negedge clk);
      set_in(w, 1'b0, 24'($urandom), 5'($urandom));
      sv_high = 1'b0;
      if (c == 1) check("busy_after_accept", longint'(o_busy(w)), 1);
      if (o_valid(w)) begin
        seen = c;
        check("out_data", o_data(w), exp_d);
        check("out_sat", longint'(o_sat(w)), longint'(exp_s));
      end
      if (c == drop1 || c == drop2) begin
        set_in(w, 1'b1, 24'($urandom), 5'($urandom));
        sv_high = 1'b1;
        #1;
        check("sample_dropped", longint'(o_dropped(w)), 1);
      end
      if (seen != 0) break;
    end
    check("latency", longint'(seen), longint'(lat));
    if (sv_high) begin
      @(negedge clk);
      set_in(w, 1'b0, 24'h0, 5'h0);
    end
  endtask

  // Accept a sample and pulse reset at cycle rst_c of RUN; no result may appear.
  task automatic send_abort(input int w, input logic [23:0] raw, input int rst_c);
    int nvalid;
    nvalid = 0;
    @(negedge clk);
    set_in(w, 1'b1, raw, 5'd0);
    for (int c = 1; c <= ntaps[w] + 6; c++) begin
      @(negedge clk);
      set_in(w, 1'b0, 24'h0, 5'd0);
      reset = (c == rst_c);
      if (o_valid(w)) nvalid++;
    end
    model_clear();
    check("abort_no_out_valid", longint'(nvalid), 0);
    check("abort_busy", longint'(o_busy(w)), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  function automatic logic [23:0] mk(input logic signed [15:0] x);
    logic [7:0] lo;
    lo = 8'($urandom);
    return {x, lo};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_in(0, 1'b0, 24'h0, 5'h0);
    set_in(1, 1'b0, 24'h0, 5'h0);
    for (int k = 0; k < 10; k++) coef[k] = 16'(k + 1);
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(bus10.out_valid), 0);
    check("rst_out_data", longint'(bus10.out_data), 0);
    check("rst_out_sat", longint'(bus10.out_sat), 0);
    check("rst_busy", longint'(bus10.busy), 0);
    check("rst_dropped", longint'(bus10.sample_dropped), 0);
    check("rst_coef_addr", longint'(bus10.coef_addr), 0);
    check("rst_out_valid_5", longint'(bus5.out_valid), 0);
    reset = 1'b0;

    // Impulse response: h[k] = k+1 shows up as 1..10, then 0.
    send(0, 24'h000100, 5'd0, 0, 0);
    repeat (10) send(0, mk(16'sd0), 5'd0, 0, 0);

    // Step response with unit coefficients.
    for (int k = 0; k < 10; k++) coef[k] = 16'sd1;
    repeat (12) send(0, mk(16'sd100), 5'd0, 0, 0);

    // Saturation at both rails.
    for (int k = 0; k < 10; k++) coef[k] = 16'sh7FFF;
    repeat (10) send(0, mk(16'sh7FFF), 5'd0, 0, 0);
    repeat (10) send(0, mk(16'sh8000), 5'd0, 0, 0);

    // Gain shift, including floor on a negative value from a fresh history.
    for (int k = 0; k < 10; k++) coef[k] = 16'sd1;
    repeat (10) send(0, mk(16'sd4), 5'd2, 0, 0);
    do_reset();
    send(0, mk(-16'sd3), 5'd1, 0, 0);

    // Samples arriving while busy, including alongside out_valid, are dropped.
    for (int k = 0; k < 10; k++) coef[k] = 16'(k + 1);
    send(0, mk(16'(250)), 5'd0, 5, 13);
    send(0, mk(16'(-77)), 5'd0, 0, 0);

    // Reset in the middle of RUN, then an impulse on the cleared history.
    repeat (3) send(0, mk(16'($urandom)), 5'd0, 0, 0);
    send_abort(0, mk(16'sd1234), 6);
    send(0, 24'h000100, 5'd0, 0, 0);
    repeat (3) send(0, mk(16'sd0), 5'd0, 0, 0);

    // Five-tap instance: impulse wraps the non-power-of-2 history.
    send(1, 24'h000100, 5'd0, 0, 0);
    repeat (7) send(1, mk(16'sd0), 5'd0, 0, 0);

    // Randomised samples, coefficients and gain shifts.
    for (int k = 0; k < 10; k++) coef[k] = 16'($urandom);
    repeat (20) send(0, 24'($urandom), 5'($urandom_range(0, 31)), 0, 0);
    repeat (12) send(1, 24'($urandom), 5'($urandom_range(0, 20)), 0, 0);
    for (int k = 0; k < 10; k++) coef[k] = 16'($urandom_range(0, 65535));
    repeat (10) send(0, mk(16'($urandom)), 5'($urandom_range(0, 8)), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
